hornet_com_rx: RTL and testbench
================================

// Module: hornet_com_rx
// PURPOSE
// Target (receive) end of the hornet inter-node comm link. Accepts 18-bit words
// from up to four neighbours (n/s/w/e) over a 4-phase req/ack handshake and
// holds one word per direction. Serves core port reads, including multi-port
// reads, with round-robin arbitration. Sits between the neighbour-node link
// wires and the hornet core's port-read path.
// PARAMETERS
// W     18  data word width
// SYNC  2   flop stages on each incoming req (0 = none, same-clock neighbours)
// PORTS
// clk          in   1   clock, rising edge
// reset_n      in   1   asynchronous reset, active-low
// t_com_n_dat  in   W   north word, stable while t_com_n_req=1
// t_com_n_req  in   1   north request (4-phase)
// t_com_n_ack  out  1   north acknowledge
// t_com_{s,w,e}_{dat,req,ack}   same as north, per direction
// rd_req       in   1   core read request; held until rd_vld
// rd_sel       in   4   direction mask {e,w,s,n}; several bits set = multiport read
// rd_vld       out  1   one-cycle pulse: rd_dat/rd_src valid
// rd_dat       out  W   delivered word
// rd_src       out  4   one-hot source {e,w,s,n} of rd_dat
// full         out  4   buffer-occupied flags {e,w,s,n}
// BEHAVIOUR
// Reset: all t_com_*_ack=0, full=0, rd_vld=0, rd_dat=0, rd_src=0, rr=0 (north).
//   A reset mid-transfer discards buffered words and drops ack immediately.
// Per-direction FSM, on synchronized req (rq = req delayed SYNC cycles):
//   IDLE : ack=0. If rq=1 and full[d]=0: buf[d]<=dat, full[d]<=1, go ACK.
//          If rq=1 and full[d]=1: stay IDLE, ack=0 (backpressure).
//   ACK  : ack=1. If rq=0: go IDLE, ack<=0. The next word needs a fresh rq rise.
//   dat is sampled raw in the capture cycle; the sender guarantees stability.
//   Capture-to-ack latency: 1 clk after rq is seen.
// Read path:
//   cand = rd_sel & full. If rd_req=1, rd_vld=0, and cand!=0: grant direction g,
//     the first set bit of cand searching rr, rr+1, ... mod 4.
//   Next edge: rd_vld<=1, rd_dat<=buf[g], rd_src<=onehot(g), full[g]<=0, rr<=g+1 mod 4.
//   rd_vld is 1 cycle. rd_dat/rd_src hold their value until the next grant.
//   rd_req is ignored in the rd_vld cycle, so grants are at least 2 cycles apart.
//   cand=0 while rd_req=1: wait, no timeout. rd_sel=0 never completes; illegal.
// Boundaries:
//   Freed buffer can recapture no earlier than the cycle after full[g] clears.
//     No same-edge capture and clear on one buffer.
//   Simultaneous captures on several directions are independent; all proceed.
//   rd_sel may change while waiting; arbitration uses the current value.
//   rr wraps e->n.
// TESTING
// 1 SYNC=0. North sends 0x2AAAA. Expected: ack=1 one cycle after req, full=0001.
//   Then rd_req with rd_sel=0001. Expected: rd_vld next cycle, rd_dat=0x2AAAA,
//   rd_src=0001, full=0000.
// 2 North word pending, not read. Second req. Expected: ack stays 0 until rd
//   consumes, then capture and ack.
// 3 All four full (n=1, s=2, w=3, e=4). rd_sel=1111, four reads.
//   Expected: order n,s,w,e, rr back at n.
// 4 rd_req with rd_sel=0100 and no words. Expected: no rd_vld.
//   West sends 0x3FFFF. Expected: rd_vld 1 cycle after capture, rd_dat=0x3FFFF.
// 5 SYNC=2. Expected: ack rises 3 clk after req and falls 3 clk after req drops.
// 6 reset_n low during ACK with full=1. Expected: ack=0, full=0 asynchronously.
//   After release, req still high is recaptured as a new word.

Source files
------------

// File: rtl/hornet_com_rx.sv
// hornet_com_rx: receive end of the hornet inter-node link.
// Four neighbour lanes (n/s/w/e), each with a req synchronizer, a 4-phase
// capture FSM and a one-word buffer. A round-robin read port drains them.

// Per-direction lane: synchronizer, capture FSM, one-word buffer.
module hornet_com_rx_lane #(
  parameter int W    = 18,
  parameter int SYNC = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] dat,
  input  logic         req,
  input  logic         clr,
  output logic         ack,
  output logic         full,
  output logic [W-1:0] word
);
  typedef enum logic {ST_IDLE, ST_ACK} state_e;

  state_e         state_q, state_d;
  logic           full_q, full_d;
  logic [W-1:0]   word_q, word_d;
  logic           rq;

  generate
    if (SYNC == 0) begin : g_nosync
      assign rq = req;
    end else begin : g_sync
      logic [SYNC-1:0] sync_q, sync_d;
      // Shift the raw req through SYNC flops; rq is the oldest stage.
      always_comb sync_d = (sync_q << 1) | SYNC'(req);
      // Synchronizer register.
      always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) sync_q <= '0;
        else          sync_q <= sync_d;
      assign rq = sync_q[SYNC-1];
    end
  endgenerate

  // Capture FSM. Clear only hits a full buffer, and capture only an empty
  // one, so the two never meet on the same edge.
  always_comb begin
    state_d = state_q;
    full_d  = full_q;
    word_d  = word_q;
    if (clr) full_d = 1'b0;
    case (state_q)
      ST_IDLE: if (rq && !full_q) begin
        word_d  = dat;
        full_d  = 1'b1;
        state_d = ST_ACK;
      end
      ST_ACK:  if (!rq) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Lane state registers.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= ST_IDLE;
      full_q  <= 1'b0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      full_q  <= full_d;
      word_q  <= word_d;
    end

  assign ack  = (state_q == ST_ACK);
  assign full = full_q;
  assign word = word_q;
endmodule

module hornet_com_rx #(
  parameter int W    = 18,
  parameter int SYNC = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] t_com_n_dat,
  input  logic         t_com_n_req,
  output logic         t_com_n_ack,
  input  logic [W-1:0] t_com_s_dat,
  input  logic         t_com_s_req,
  output logic         t_com_s_ack,
  input  logic [W-1:0] t_com_w_dat,
  input  logic         t_com_w_req,
  output logic         t_com_w_ack,
  input  logic [W-1:0] t_com_e_dat,
  input  logic         t_com_e_req,
  output logic         t_com_e_ack,
  input  logic         rd_req,
  input  logic [3:0]   rd_sel,
  output logic         rd_vld,
  output logic [W-1:0] rd_dat,
  output logic [3:0]   rd_src,
  output logic [3:0]   full
);
  localparam int NUM_LANES = 4;

  logic [NUM_LANES-1:0][W-1:0] lane_dat, lane_word;
  logic [NUM_LANES-1:0]        lane_req, lane_ack, lane_full, lane_clr;

  // Lane index 0..3 = n, s, w, e.
  assign lane_dat = {t_com_e_dat, t_com_w_dat, t_com_s_dat, t_com_n_dat};
  assign lane_req = {t_com_e_req, t_com_w_req, t_com_s_req, t_com_n_req};
  assign {t_com_e_ack, t_com_w_ack, t_com_s_ack, t_com_n_ack} = lane_ack;

  generate
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      hornet_com_rx_lane #(.W(W), .SYNC(SYNC)) u_lane (
        .clk     (clk),
        .reset_n (reset_n),
        .dat     (lane_dat[i]),
        .req     (lane_req[i]),
        .clr     (lane_clr[i]),
        .ack     (lane_ack[i]),
        .full    (lane_full[i]),
        .word    (lane_word[i])
      );
    end
  endgenerate

  logic [1:0]   rr_q, rr_d, gnt_idx;
  logic         gnt_any, fire;
  logic [3:0]   cand;
  logic         rd_vld_q, rd_vld_d;
  logic [W-1:0] rd_dat_q, rd_dat_d;
  logic [3:0]   rd_src_q, rd_src_d;

  // Round-robin pick: first candidate at or after rr, wrapping e->n.
  // No grant in the rd_vld cycle, so the held rd_req cannot double-fire.
  always_comb begin
    cand    = rd_sel & lane_full;
    gnt_any = 1'b0;
    gnt_idx = rr_q;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (!gnt_any && cand[rr_q + 2'(i)]) begin
        gnt_any = 1'b1;
        gnt_idx = rr_q + 2'(i);
      end
    end
    fire     = rd_req && !rd_vld_q && gnt_any;
    rd_vld_d = fire;
    rd_dat_d = fire ? lane_word[gnt_idx] : rd_dat_q;
    rd_src_d = fire ? (4'b0001 << gnt_idx) : rd_src_q;
    rr_d     = fire ? gnt_idx + 2'd1 : rr_q;
    lane_clr = fire ? (4'b0001 << gnt_idx) : 4'b0000;
  end

  // Read-port registers.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      rr_q     <= 2'd0;
      rd_vld_q <= 1'b0;
      rd_dat_q <= '0;
      rd_src_q <= 4'b0000;
    end else begin
      rr_q     <= rr_d;
      rd_vld_q <= rd_vld_d;
      rd_dat_q <= rd_dat_d;
      rd_src_q <= rd_src_d;
    end

  assign rd_vld = rd_vld_q;
  assign rd_dat = rd_dat_q;
  assign rd_src = rd_src_q;
  assign full   = lane_full;
endmodule

// File: tb/tb_hornet_com_rx.sv
// Bench for hornet_com_rx: dut0 (SYNC=0) carries most scenarios through a
// read scoreboard; dut2 (SYNC=2) checks synchronizer latency on north.
module tb_hornet_com_rx;
  logic              clk = 1'b0;
  logic              reset_n;
  logic [3:0]        req;
  logic [3:0][17:0]  dat;
  logic              rd_req;
  logic [3:0]        rd_sel;
  logic              ack_n, ack_s, ack_w, ack_e;
  logic              rd_vld;
  logic [17:0]       rd_dat;
  logic [3:0]        rd_src, full;
  wire  [3:0]        ack = {ack_e, ack_w, ack_s, ack_n};

  logic              req2;
  logic              ack2_n, ack2_s, ack2_w, ack2_e, rd_vld2;
  logic [17:0]       rd_dat2;
  logic [3:0]        rd_src2, full2;
  wire  [3:0]        ack2 = {ack2_e, ack2_w, ack2_s, ack2_n};

  int nvec = 0;
  int nerr = 0;

  typedef struct packed { logic [17:0] dat; logic [3:0] src; } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  hornet_com_rx #(.W(18), .SYNC(0)) dut0 (
    .clk(clk), .reset_n(reset_n),
    .t_com_n_dat(dat[0]), .t_com_n_req(req[0]), .t_com_n_ack(ack_n),
    .t_com_s_dat(dat[1]), .t_com_s_req(req[1]), .t_com_s_ack(ack_s),
    .t_com_w_dat(dat[2]), .t_com_w_req(req[2]), .t_com_w_ack(ack_w),
    .t_com_e_dat(dat[3]), .t_com_e_req(req[3]), .t_com_e_ack(ack_e),
    .rd_req(rd_req), .rd_sel(rd_sel), .rd_vld(rd_vld), .rd_dat(rd_dat),
    .rd_src(rd_src), .full(full)
  );

  hornet_com_rx #(.W(18), .SYNC(2)) dut2 (
    .clk(clk), .reset_n(reset_n),
    .t_com_n_dat(18'h12345), .t_com_n_req(req2), .t_com_n_ack(ack2_n),
    .t_com_s_dat(18'h0), .t_com_s_req(1'b0), .t_com_s_ack(ack2_s),
    .t_com_w_dat(18'h0), .t_com_w_req(1'b0), .t_com_w_ack(ack2_w),
    .t_com_e_dat(18'h0), .t_com_e_req(1'b0), .t_com_e_ack(ack2_e),
    .rd_req(1'b0), .rd_sel(4'b0000), .rd_vld(rd_vld2), .rd_dat(rd_dat2),
    .rd_src(rd_src2), .full(full2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic align();
    @(posedge clk); #1;
  endtask

  // Full 4-phase transfer on dut0 direction d.
  task automatic send(input int d, input logic [17:0] v);
    int n;
    align();
    dat[d] = v;
    req[d] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!ack[d] && n < 10);
    chk("send_ack_rise", 32'(ack[d]), 32'd1);
    align();
    req[d] = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (ack[d] && n < 10);
    chk("send_ack_fall", 32'(ack[d]), 32'd0);
  endtask

  // Issue a read; the monitor checks the delivered word. Returns in the rd_vld cycle.
  task automatic rd(input logic [3:0] sel, input logic [17:0] ed, input logic [3:0] es);
    int n;
    align();
    sb.push_back(exp_t'{dat: ed, src: es});
    rd_sel = sel;
    rd_req = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!rd_vld && n < 20);
    if (!rd_vld) begin
      nvec++; nerr++;
      $display("FAIL rd_timeout: got no rd_vld expected rd_vld for sel %b", sel);
      void'(sb.pop_back());
    end
    rd_req = 1'b0;
  endtask

  // Scoreboard monitor: every rd_vld pulse pops and compares one entry.
  always @(negedge clk) begin
    if (reset_n && rd_vld) begin
      if (sb.size() == 0) begin
        nvec++; nerr++;
        $display("FAIL unexpected_rd_vld: got dat %0h src %b expected no read", rd_dat, rd_src);
      end else begin
        mon_e = sb.pop_front();
        chk("rd_dat", 32'(rd_dat), 32'(mon_e.dat));
        chk("rd_src", 32'(rd_src), 32'(mon_e.src));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; req = '0; dat = '0; rd_req = 1'b0; rd_sel = '0; req2 = 1'b0;
    #12;
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_rd_vld", 32'(rd_vld), 32'd0);
    chk("rst_rd_dat", 32'(rd_dat), 32'd0);
    chk("rst_rd_src", 32'(rd_src), 32'd0);
    chk("rst2_outs", {rd_vld2, rd_dat2, rd_src2, full2, ack2}, 32'd0);
    reset_n = 1'b1;

    // 1: single north word, ack one cycle after req, then read it.
    align();
    dat[0] = 18'h2AAAA; req[0] = 1'b1;
    @(negedge clk); chk("t1_ack_pre", 32'(ack), 32'd0);
    @(negedge clk); chk("t1_ack", 32'(ack), 32'b0001);
    chk("t1_full", 32'(full), 32'b0001);
    align(); req[0] = 1'b0;
    @(negedge clk); @(negedge clk); chk("t1_ack_fall", 32'(ack), 32'd0);
    rd(4'b0001, 18'h2AAAA, 4'b0001);
    @(negedge clk); chk("t1_full_clr", 32'(full), 32'd0);
    @(negedge clk); chk("t1_vld_pulse", 32'(rd_vld), 32'd0);
    chk("t1_dat_hold", 32'(rd_dat), 32'h2AAAA);

    // 2: backpressure while the north buffer is still full.
    send(0, 18'h11111);
    align();
    dat[0] = 18'h22222; req[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); chk("t2_bp_ack", 32'(ack[0]), 32'd0);
    end
    chk("t2_bp_full", 32'(full), 32'b0001);
    rd(4'b0001, 18'h11111, 4'b0001);
    @(negedge clk); chk("t2_no_same_edge", {ack, full}, 32'd0);
    @(negedge clk); chk("t2_recap", {ack, full}, {4'b0001, 4'b0001});
    align(); req[0] = 1'b0;
    @(negedge clk); @(negedge clk); chk("t2_ack_fall", 32'(ack), 32'd0);
    rd(4'b0001, 18'h22222, 4'b0001);

    // 3: fresh reset (rr at n), all four captured together, multiport reads.
    align();
    reset_n = 1'b0; #2; reset_n = 1'b1;
    align();
    dat[0] = 18'd1; dat[1] = 18'd2; dat[2] = 18'd3; dat[3] = 18'd4;
    req = 4'b1111;
    @(negedge clk); @(negedge clk);
    chk("t3_ack_all", 32'(ack), 32'b1111);
    chk("t3_full_all", 32'(full), 32'b1111);
    align(); req = 4'b0000;
    @(negedge clk); @(negedge clk); chk("t3_ack_fall", 32'(ack), 32'd0);
    rd(4'b1111, 18'd1, 4'b0001);
    rd(4'b1111, 18'd2, 4'b0010);
    rd(4'b1111, 18'd3, 4'b0100);
    rd(4'b1111, 18'd4, 4'b1000);
    @(negedge clk); chk("t3_full_empty", 32'(full), 32'd0);
    // rr wrapped to n: with n and e both full, n wins, then e.
    send(0, 18'd5);
    send(3, 18'd6);
    rd(4'b1001, 18'd5, 4'b0001);
    rd(4'b1001, 18'd6, 4'b1000);

    // 4: read waits on an empty west buffer, completes after capture.
    align();
    sb.push_back(exp_t'{dat: 18'h3FFFF, src: 4'b0100});
    rd_sel = 4'b0100; rd_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); chk("t4_wait_novld", 32'(rd_vld), 32'd0);
    end
    align();
    dat[2] = 18'h3FFFF; req[2] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t4_capture", {rd_vld, full}, {1'b0, 4'b0100});
    @(negedge clk); chk("t4_vld_latency", 32'(rd_vld), 32'd1);
    align(); rd_req = 1'b0; req[2] = 1'b0;
    @(negedge clk); @(negedge clk); chk("t4_ack_fall", 32'(ack), 32'd0);

    // 5: SYNC=2 instance, ack edges lag req edges by 3 clocks.
    align(); req2 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); chk("t5_ack_rise", 32'(ack2), (i == 3) ? 32'b0001 : 32'd0);
    end
    chk("t5_full", 32'(full2), 32'b0001);
    align(); req2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); chk("t5_ack_fall", 32'(ack2), (i == 3) ? 32'd0 : 32'b0001);
    end

    // 6: asynchronous reset during ACK, then recapture of the held req.
    align();
    dat[0] = 18'h15555; req[0] = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("t6_pre_ack", {ack, full}, {4'b0001, 4'b0001});
    #2 reset_n = 1'b0;
    #1 chk("t6_async_clr", {ack, full}, 32'd0);
    dat[0] = 18'h0ABCD;
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk); chk("t6_recap", {ack, full}, {4'b0001, 4'b0001});
    align(); req[0] = 1'b0;
    @(negedge clk); @(negedge clk);
    rd(4'b0001, 18'h0ABCD, 4'b0001);

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
